pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder that succeeds the 4-bit combinational CLA. Operands are split into 4-bit lookahead groups. Each group is resolved in its own register stage, with the group carry passed forward, so the adder closes timing at any width while sustaining one result per cycle. A valid/ready handshake on both sides lets it sit directly inside streaming datapaths. It also reports signed overflow.

---
 rtl/pipelined_cla_adder.sv | 140 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one 4-bit lookahead group per register stage.
// Define PCLA_SUB_EN to add the `sub` port (a - b - cin when sub=1).
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PCLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    logic             en;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

`ifdef PCLA_SUB_EN
    // Subtraction folds into the operand: a + ~b + ~cin == a - b - cin.
    assign b_in = sub ? ~b : b;
    assign c_in = cin ^ sub;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Returns {c3, c4, s[3:0]} with every carry in two-level form.
    function automatic logic [5:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c3, c4, p ^ {c3, c2, c1, c0}};
    endfunction

    for (genvar k = 0; k < NG; k++) begin : stg
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic             v_i;
        logic [5:0]       r;
        logic [WIDTH-1:0] s_n;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             o_q;
        logic             v_q;

        if (k == 0) begin : head
            assign a_i = a;
            assign b_i = b_in;
            assign s_i = '0;
            assign c_i = c_in;
            assign v_i = in_valid;
        end else begin : link
            assign a_i = stg[k-1].a_q;
            assign b_i = stg[k-1].b_q;
            assign s_i = stg[k-1].s_q;
            assign c_i = stg[k-1].c_q;
            assign v_i = stg[k-1].v_q;
        end

        assign r = cla4(a_i[4*k +: 4], b_i[4*k +: 4], c_i);

        always_comb begin
            s_n           = s_i;
            s_n[4*k +: 4] = r[3:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= v_i;
            end
        end

        // Bubbles leave data registers untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                o_q <= 1'b0;
            end else if (en && v_i) begin
                a_q <= a_i;
                b_q <= b_i;
                s_q <= s_n;
                c_q <= r[4];
                o_q <= r[5] ^ r[4];
            end
        end

        if (k == NG - 1) begin : tail
            logic unused_ops;
            assign unused_ops = ^{a_q, b_q};
        end else begin : mid
            logic unused_ovf;
            assign unused_ovf = o_q;
        end
    end

    assign out_valid = stg[NG-1].v_q;
    assign sum       = stg[NG-1].s_q;
    assign cout      = stg[NG-1].c_q;
    assign ovf       = stg[NG-1].o_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases, random streaming
// against an arithmetic reference model, mid-stream reset, 4-bit instance.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int NG = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    logic          iv4 = 1'b0;
    logic          ir4;
    logic [3:0]    a4 = '0;
    logic [3:0]    b4 = '0;
    logic          cin4 = 1'b0;
    logic          sub4 = 1'b0;
    logic          ov4;
    logic          or4 = 1'b1;
    logic [3:0]    s4;
    logic          co4;
    logic          of4;

    int            vectors = 0;
    int            errors = 0;
    logic [17:0]   exp_q[$];
    logic [17:0]   got_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PCLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef PCLA_SUB_EN
        .sub(sub4),
`endif
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(of4)
    );

    // Reference: integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [17:0] model(
        input logic [15:0] x, input logic [15:0] y,
        input logic c, input logic s
    );
        int ur;
        int sr;
        logic co;
        if (s) begin
            ur = int'(x) - int'(y) - int'(c);
            sr = int'($signed(x)) - int'($signed(y)) - int'(c);
            co = (ur >= 0);
        end else begin
            ur = int'(x) + int'(y) + int'(c);
            sr = int'($signed(x)) + int'($signed(y)) + int'(c);
            co = (ur > 65535);
        end
        return {(sr > 32767 || sr < -32768), co, 16'(ur)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) got_q.push_back({ovf, cout, sum});
        end
    end

    // Stimulus helper: one operand into an empty pipe, waits for its result.
    task automatic run_one(
        input logic [15:0] x, input logic [15:0] y,
        input logic c, input logic s,
        output logic [17:0] res, output int lat
    );
        bit found;
        a = x; b = y; cin = c; sub = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        found = 0; lat = 0; res = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                res = {ovf, cout, sum};
                found = 1;
            end
        end
        if (!found) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, ovf, cout, sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b o=%b c=%b s=%h want all 0",
                     out_valid, ovf, cout, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= NG; i++) begin
            @(negedge clk);
            vectors++;
            if (i < NG) begin
                if (out_valid !== 1'b0 || sum !== 16'h0) begin
                    errors++;
                    $display("FAIL first_early[%0d]: got v=%b s=%h want v=0 s=0",
                             i, out_valid, sum);
                end
            end else if ({out_valid, ovf, cout, sum} !== {3'b100, 16'h0003}) begin
                errors++;
                $display("FAIL first_result: got v=%b o=%b c=%b s=%h want v=1 o=0 c=0 s=0003",
                         out_valid, ovf, cout, sum);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corners;
        logic [15:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] tb[4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
        logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [17:0] te[4] = '{{2'b01, 16'h0000}, {2'b01, 16'hFFFF},
                               {2'b10, 16'h8000}, {2'b11, 16'h0000}};
        logic [17:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_one(ta[i], tb[i], tc[i], 1'b0, res, lat);
            vectors++;
            if (res !== te[i] || lat != NG) begin
                errors++;
                $display("FAIL corner[%0d]: got %h lat %0d want %h lat %0d",
                         i, res, lat, te[i], NG);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          sent = 0;
        int          cyc = 0;
        bit          acc;
        bit          stalled = 0;
        logic [18:0] held = '0;
        exp_q.delete(); got_q.delete();
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef PCLA_SUB_EN
        sub = 1'($urandom);
`endif
        in_valid = 1'b1;
        while (got_q.size() < 20 && cyc < 400) begin
            cyc++;
            out_ready = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready[%0d]: got %b want %b", cyc, in_ready,
                         !(out_valid && !out_ready));
            end
            if (stalled) begin
                vectors++;
                if ({out_valid, ovf, cout, sum} !== held) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got %h want %h", cyc,
                             {out_valid, ovf, cout, sum}, held);
                end
            end
            stalled = out_valid && !out_ready;
            held = {out_valid, ovf, cout, sum};
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 20) begin
                    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef PCLA_SUB_EN
                    sub = 1'($urandom);
`endif
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 20 || exp_q.size() != 20) begin
            errors++;
            $display("FAIL stream_count: got %0d results %0d accepts want 20",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 20 && i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [17:0] res;
        logic [15:0] x;
        logic [15:0] y;
        int lat;
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h4321; b = 16'h2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, ovf, cout, sum} !== '0) begin
                errors++;
                $display("FAIL post_reset[%0d]: got v=%b o=%b c=%b s=%h want all 0",
                         i, out_valid, ovf, cout, sum);
            end
        end
        @(posedge clk); #1;
        x = 16'($urandom); y = 16'($urandom);
        run_one(x, y, 1'b1, 1'b0, res, lat);
        vectors++;
        if (res !== model(x, y, 1'b1, 1'b0) || lat != NG) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d want %h lat %0d",
                     res, lat, model(x, y, 1'b1, 1'b0), NG);
        end
    endtask

    task automatic test_sub;
`ifdef PCLA_SUB_EN
        logic [17:0] res;
        logic [15:0] x;
        logic [15:0] y;
        logic c;
        int lat;
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, res, lat);
        vectors++;
        if (res !== {2'b00, 16'hFFFE} || lat != NG) begin
            errors++;
            $display("FAIL sub_5_7: got %h lat %0d want 0fffe lat %0d", res, lat, NG);
        end
        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            run_one(x, y, c, 1'b1, res, lat);
            vectors++;
            if (res !== model(x, y, c, 1'b1)) begin
                errors++;
                $display("FAIL sub_rand[%0d]: got %h want %h", i, res,
                         model(x, y, c, 1'b1));
            end
        end
        sub = 1'b0;
`endif
    endtask

    task automatic test_width4;
        logic [3:0] ta[3] = '{4'h3, 4'hF, 4'h3};
        logic [3:0] tb[3] = '{4'h5, 4'h1, 4'h5};
        logic       ts[3] = '{1'b0, 1'b0, 1'b1};
        logic [6:0] te[3] = '{{3'b110, 4'h8}, {3'b101, 4'h0}, {3'b100, 4'hE}};
        int n = 2;
`ifdef PCLA_SUB_EN
        n = 3;
`endif
        or4 = 1'b1;
        for (int i = 0; i < n; i++) begin
            a4 = ta[i]; b4 = tb[i]; sub4 = ts[i]; cin4 = 1'b0; iv4 = 1'b1;
            @(posedge clk); #1;
            iv4 = 1'b0;
            @(negedge clk);
            vectors++;
            if ({ov4, of4, co4, s4} !== te[i]) begin
                errors++;
                $display("FAIL w4[%0d]: got v=%b o=%b c=%b s=%h want %b", i,
                         ov4, of4, co4, s4, te[i]);
            end
            @(posedge clk); #1;
        end
        sub4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first();
        test_corners();
        test_back_to_back();
        test_reset_midstream();
        test_sub();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
